mac_status_pipe: RTL and testbench



---
 rtl/mac_status_pipe.sv | 135 +++++++++++++
 tb/tb_mac_status_pipe.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_status_pipe.sv
// Elastic valid/ready pipe for the FP MAC adder-stage status bits, with per-run overflow counting.
// Optional backpressure counter on stall_cycles is enabled by defining MAC_STATUS_STALL_CNT_EN.
module mac_status_pipe #(
  parameter int DEPTH  = 2,
  parameter int FLAG_W = 3,
  parameter int CNT_W  = 8
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_current_sign,
  input  logic              in_ov_sign,
  input  logic [FLAG_W-1:0] in_flags,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sign,
  output logic              out_ov_sign,
  output logic [FLAG_W-1:0] out_flags,
  output logic              out_last,
  output logic              run_done,
  output logic [CNT_W-1:0]  run_ov_count,
  output logic [15:0]       stall_cycles
);

  typedef struct packed {
    logic              sign;
    logic              ov_sign;
    logic [FLAG_W-1:0] flags;
    logic              last;
  } entry_t;

  entry_t           st      [DEPTH];
  entry_t           src     [DEPTH];
  entry_t           in_entry;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] ld;
  logic [DEPTH-1:0] src_vld;

  // A stage may load when it or any stage downstream of it has room, or the output drains.
  for (genvar k = 0; k < DEPTH; k++) begin : g_ld
    assign ld[k] = out_ready || !(&vld[DEPTH-1:k]);
  end

  assign in_ready = !flush && ld[0];
  assign in_entry = {in_current_sign, in_ov_sign, in_flags, in_last};

  always_comb begin
    src_vld = '0;
    for (int k = 0; k < DEPTH; k++) src[k] = '0;
    src[0]     = in_entry;
    src_vld[0] = in_valid && in_ready;
    for (int k = 1; k < DEPTH; k++) begin
      src[k]     = st[k-1];
      src_vld[k] = vld[k-1];
    end
  end

  // Data only updates when a valid entry lands, so empty stages stay quiet.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      vld <= '0;
      for (int k = 0; k < DEPTH; k++) st[k] <= '0;
    end else if (flush) begin
      vld <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ld[k]) begin
          vld[k] <= src_vld[k];
          if (src_vld[k]) st[k] <= src[k];
        end
      end
    end
  end

  assign out_valid   = vld[DEPTH-1];
  assign out_sign    = st[DEPTH-1].sign;
  assign out_ov_sign = st[DEPTH-1].ov_sign;
  assign out_flags   = st[DEPTH-1].flags;
  assign out_last    = st[DEPTH-1].last;

  logic             xfer;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W:0]   cnt_sum;

  assign xfer = out_valid && out_ready;

  always_comb begin
    cnt_sum  = {1'b0, cnt} + {{CNT_W{1'b0}}, out_ov_sign};
    cnt_next = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  // A handshake that coincides with flush is dropped from the run accounting.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      cnt          <= '0;
      run_done     <= 1'b0;
      run_ov_count <= '0;
    end else if (flush) begin
      cnt      <= '0;
      run_done <= 1'b0;
    end else if (xfer) begin
      if (out_last) begin
        run_ov_count <= cnt_next;
        cnt          <= '0;
        run_done     <= 1'b1;
      end else begin
        cnt      <= cnt_next;
        run_done <= 1'b0;
      end
    end else begin
      run_done <= 1'b0;
    end
  end

`ifdef MAC_STATUS_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clock) begin
    if (!resetn || flush) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mac_status_pipe.sv
// Scoreboard bench for mac_status_pipe: a DEPTH=2/CNT_W=8 instance plus a CNT_W=2 twin for saturation.
module tb_mac_status_pipe;

  logic        clock = 1'b0;
  logic        resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_current_sign;
  logic        in_ov_sign;
  logic [2:0]  in_flags;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic        out_ov_sign;
  logic [2:0]  out_flags;
  logic        out_last;
  logic        run_done;
  logic [7:0]  run_ov_count;
  logic [15:0] stall_cycles;

  logic        s_in_ready, s_out_valid, s_out_sign, s_out_ov_sign, s_out_last, s_run_done;
  logic [2:0]  s_out_flags;
  logic [1:0]  s_run_ov_count;
  logic [15:0] s_stall_cycles;

  int total = 0;
  int bad   = 0;
  bit mon_en = 1'b0;

  logic [5:0] q[$];
  logic [7:0] m_cnt = '0, m_roc = '0;
  logic [1:0] m_cnt_s = '0, m_roc_s = '0;
  logic       m_rd = 1'b0;

  always #5 clock = ~clock;

  mac_status_pipe #(.DEPTH(2), .FLAG_W(3), .CNT_W(8)) u_dut (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_current_sign(in_current_sign), .in_ov_sign(in_ov_sign),
    .in_flags(in_flags), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_ov_sign(out_ov_sign),
    .out_flags(out_flags), .out_last(out_last),
    .run_done(run_done), .run_ov_count(run_ov_count), .stall_cycles(stall_cycles)
  );

  mac_status_pipe #(.DEPTH(2), .FLAG_W(3), .CNT_W(2)) u_sat (
    .clock(clock), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_current_sign(in_current_sign), .in_ov_sign(in_ov_sign),
    .in_flags(in_flags), .in_last(in_last),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_sign(s_out_sign), .out_ov_sign(s_out_ov_sign),
    .out_flags(s_out_flags), .out_last(s_out_last),
    .run_done(s_run_done), .run_ov_count(s_run_ov_count), .stall_cycles(s_stall_cycles)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send(input logic s, input logic o, input logic [2:0] f, input logic l);
    logic acc;
    acc             = 1'b0;
    in_valid        = 1'b1;
    in_current_sign = s;
    in_ov_sign      = o;
    in_flags        = f;
    in_last         = l;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = in_ready;
      tick();
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Monitor: sampled mid-cycle, decides what the coming edge will do.
  always @(negedge clock) begin
    if (mon_en) begin
      chk("run_done", run_done, m_rd);
      chk("sat_run_done", s_run_done, m_rd);
      chk("run_ov_count", run_ov_count, m_roc);
      chk("sat_run_ov_count", s_run_ov_count, m_roc_s);
      if (!resetn) begin
        q.delete();
        m_cnt = '0; m_roc = '0; m_cnt_s = '0; m_roc_s = '0; m_rd = 1'b0;
      end else begin
        if (out_valid && out_ready) begin
          if (q.size() == 0) chk("unexpected_output", 32'd1, 32'd0);
          else chk("out_entry", {out_sign, out_ov_sign, out_flags, out_last}, q.pop_front());
        end
        if (flush) begin
          q.delete();
          m_cnt = '0; m_cnt_s = '0; m_rd = 1'b0;
        end else if (out_valid && out_ready) begin
          logic [8:0] n8;
          logic [2:0] n2;
          logic [7:0] c8;
          logic [1:0] c2;
          n8 = {1'b0, m_cnt} + {8'd0, out_ov_sign};
          n2 = {1'b0, m_cnt_s} + {2'd0, out_ov_sign};
          c8 = (n8 > 9'd255) ? 8'd255 : n8[7:0];
          c2 = (n2 > 3'd3) ? 2'd3 : n2[1:0];
          if (out_last) begin
            m_roc = c8; m_roc_s = c2; m_cnt = '0; m_cnt_s = '0; m_rd = 1'b1;
          end else begin
            m_cnt = c8; m_cnt_s = c2; m_rd = 1'b0;
          end
        end else begin
          m_rd = 1'b0;
        end
        if (!flush && in_valid && in_ready)
          q.push_back({in_current_sign, in_ov_sign, in_flags, in_last});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [4:0] bp_ov;
    logic [5:0] r6;
    logic       acc;
    int         idx;
    bp_ov = 5'b11001;
    r6    = 6'b101101;
    resetn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_current_sign = 1'b0; in_ov_sign = 1'b0; in_flags = 3'b000; in_last = 1'b0;
    repeat (3) tick();
    resetn = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_fields", {out_sign, out_ov_sign, out_flags, out_last}, 6'd0);
    chk("rst_run_done", run_done, 1'b0);
    chk("rst_run_ov_count", run_ov_count, 8'd0);
    chk("rst_stall_cycles", stall_cycles, 16'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    mon_en = 1'b1;
    tick();

    // Latency with out_ready held high
    in_valid = 1'b1; in_current_sign = 1'b1; in_ov_sign = 1'b0; in_flags = 3'b010; in_last = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("lat_edge_n", out_valid, 1'b0);
    tick();
    chk("lat_edge_n1_valid", out_valid, 1'b1);
    chk("lat_edge_n1_fields", {out_sign, out_ov_sign, out_flags, out_last}, 6'b1_0_010_0);
    tick();
    chk("lat_edge_n2", out_valid, 1'b0);
    idle(2);

    // Backpressure: out_ready low for cycles 2..5 of the stream
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      out_ready = !(c >= 2 && c <= 5);
      if (idx < 5) begin
        in_valid = 1'b1; in_current_sign = idx[0]; in_ov_sign = bp_ov[idx];
        in_flags = idx[2:0]; in_last = (idx == 4);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 2) chk("bp_in_ready_full", in_ready, 1'b0);
      acc = in_valid && in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("bp_accepted", idx, 5);
`ifdef MAC_STATUS_STALL_CNT_EN
    chk("bp_stall_cycles", stall_cycles, 16'd4);
`else
    chk("bp_stall_cycles", stall_cycles, 16'd0);
`endif
    chk("bp_run_ov_count", run_ov_count, 8'd3);

    // Run of 6 with ov 1,0,1,1,0,1
    for (int i = 0; i < 6; i++) send(i[0], r6[i], 3'(i), i == 5);
    idle(4);
    chk("run6_ov_count", run_ov_count, 8'd4);
    chk("run6_sat_ov_count", s_run_ov_count, 2'd3);
    chk("run6_done_low", run_done, 1'b0);

    send(1'b0, 1'b0, 3'b001, 1'b0);
    send(1'b1, 1'b0, 3'b100, 1'b1);
    idle(4);
    chk("run2_ov_count", run_ov_count, 8'd0);

    for (int i = 0; i < 5; i++) send(1'b1, 1'b1, 3'b000, i == 4);
    idle(4);
    chk("run5_ov_count", run_ov_count, 8'd5);
    chk("run5_sat_ov_count", s_run_ov_count, 2'd3);

    // Flush with cnt=1 and two entries stalled in the pipe
    send(1'b1, 1'b1, 3'b000, 1'b0);
    idle(3);
    out_ready = 1'b0;
    send(1'b0, 1'b1, 3'b011, 1'b0);
    send(1'b1, 1'b1, 3'b110, 1'b0);
    flush = 1'b1; in_valid = 1'b1; in_current_sign = 1'b1; in_flags = 3'b111; in_last = 1'b1;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_run_ov_hold", run_ov_count, 8'd5);
    out_ready = 1'b1;
    idle(3);
    chk("flush_no_accept", out_valid, 1'b0);
    send(1'b0, 1'b0, 3'b000, 1'b0);
    send(1'b0, 1'b1, 3'b010, 1'b1);
    idle(4);
    chk("post_flush_ov_count", run_ov_count, 8'd1);
    chk("post_flush_sat_count", s_run_ov_count, 2'd1);

    // Reset with a full, stalled pipe
    out_ready = 1'b0;
    send(1'b1, 1'b1, 3'b111, 1'b1);
    send(1'b1, 1'b0, 3'b101, 1'b0);
    tick();
    resetn = 1'b0;
    tick();
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_out_fields", {out_sign, out_ov_sign, out_flags, out_last}, 6'd0);
    chk("mid_rst_run_done", run_done, 1'b0);
    chk("mid_rst_run_ov_count", run_ov_count, 8'd0);
    chk("mid_rst_stall_cycles", stall_cycles, 16'd0);
    resetn = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    idle(3);
    chk("mid_rst_drained", out_valid, 1'b0);
    chk("queue_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
